// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl -- layer sequencer for one scalable_SA instance.
//
// Takes one layer command per handshake, then drives the array through
// layer-info load, weight load and the row-by-row ifmap stream. Array
// outputs are forwarded as result beats and counted until the layer
// completes. Completion is reported with a one-cycle done pulse and a
// sticky err flag.
//
// Ports:
//   clk, nrst           clock, asynchronous active-low reset
//   cmd_*               layer command (valid/ready handshake, accepted in IDLE)
//   wt_valid/ready/data weight block source
//   src_valid/ready/data ifmap row source
//   abort               synchronous abort of the running layer
//   sa_*  (out)         all control/data inputs of the array
//   sa_data_ov/od (in)  array output beat
//   res_valid/res_data  forwarded result beat
//   busy, done, err     status
module sa_seq_ctrl #(
    parameter int WIDTH         = 8,
    parameter int HEIGHT        = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int PSUM_WIDTH    = DATA_WIDTH*2+$clog2(HEIGHT),
    parameter int CNT_W         = 8,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                               clk,
    input  logic                               nrst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [3:0]                         cmd_w_width,
    input  logic [3:0]                         cmd_w_height,
    input  logic                               cmd_op_sel,
    input  logic [3:0]                         cmd_ifmap_w,
    input  logic [CNT_W-1:0]                   cmd_in_rows,
    input  logic [CNT_W-1:0]                   cmd_out_rows,
    input  logic                               wt_valid,
    output logic                               wt_ready,
    input  logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] wt_data,
    input  logic                               src_valid,
    output logic                               src_ready,
    input  logic [WIDTH*DATA_WIDTH-1:0]        src_data,
    input  logic                               abort,
    output logic                               sa_load_layer_info,
    output logic [3:0]                         sa_w_width,
    output logic [3:0]                         sa_w_height,
    output logic                               sa_op_sel,
    output logic [3:0]                         sa_ifmap_i_w,
    output logic                               sa_weight_iv,
    output logic [HEIGHT*WIDTH*DATA_WIDTH-1:0] sa_weight_id,
    output logic                               sa_data_iv,
    output logic [WIDTH*DATA_WIDTH-1:0]        sa_data_id,
    input  logic                               sa_data_ov,
    input  logic [WIDTH*PSUM_WIDTH-1:0]        sa_data_od,
    output logic                               res_valid,
    output logic [WIDTH*PSUM_WIDTH-1:0]        res_data,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int TW = $clog2(DRAIN_TIMEOUT+1);
    // DONE lands exactly DRAIN_TIMEOUT cycles after the last beat: the
    // decision is taken one cycle early and idle_cnt lags by one.
    localparam logic [TW-1:0] IDLE_LIM = TW'(DRAIN_TIMEOUT-2);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_GAP1, S_WLOAD, S_GAP2, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [3:0]       w_width_q, w_height_q, ifmap_w_q;
    logic             op_sel_q;
    logic [CNT_W-1:0] in_rows_q, out_rows_q, rows_sent, outs_rcvd;
    logic [CNT_W-1:0] rows_inc, outs_nx;
    logic [TW-1:0]    idle_cnt;
    logic             err_q, err_set;
    logic             accept, kill, beat;

    assign accept = (state == S_IDLE) && cmd_valid;
    assign kill   = abort && (state != S_IDLE) && (state != S_DONE);
    assign beat   = sa_data_ov && ((state == S_STREAM) || (state == S_DRAIN));

    always_comb begin
        state_nx           = state;
        cmd_ready          = 1'b0;
        sa_load_layer_info = 1'b0;
        wt_ready           = 1'b0;
        src_ready          = 1'b0;
        err_set            = 1'b0;
        rows_inc = (rows_sent != '1) ? rows_sent + CNT_W'(1) : rows_sent;
        outs_nx  = (beat && outs_rcvd != '1) ? outs_rcvd + CNT_W'(1) : outs_rcvd;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = S_CFG;
            end
            S_CFG: begin
                sa_load_layer_info = 1'b1;
                state_nx           = S_GAP1;
            end
            S_GAP1:  state_nx = S_WLOAD;
            S_WLOAD: begin
                wt_ready = 1'b1;
                if (wt_valid) state_nx = S_GAP2;
            end
            S_GAP2:  state_nx = (in_rows_q == '0) ? S_DRAIN : S_STREAM;
            S_STREAM: begin
                src_ready = (rows_sent < in_rows_q);
                if (src_valid && src_ready && rows_inc == in_rows_q) state_nx = S_DRAIN;
                if (beat && outs_rcvd == out_rows_q) err_set = 1'b1;
            end
            S_DRAIN: begin
                if (outs_nx >= out_rows_q) begin
                    state_nx = S_DONE;
                end else if (!sa_data_ov && idle_cnt >= IDLE_LIM) begin
                    state_nx = S_DONE;
                    err_set  = 1'b1;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides everything above: no handshakes or array pulses
        // may leak out in the cycle the abort is seen.
        if (kill) begin
            state_nx           = S_DONE;
            err_set            = 1'b1;
            sa_load_layer_info = 1'b0;
            wt_ready           = 1'b0;
            src_ready          = 1'b0;
        end
        sa_weight_iv = wt_ready && wt_valid;
        sa_weight_id = sa_weight_iv ? wt_data : '0;
        sa_data_iv   = src_ready && src_valid;
        sa_data_id   = sa_data_iv ? src_data : '0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            w_width_q  <= '0;
            w_height_q <= '0;
            op_sel_q   <= 1'b0;
            ifmap_w_q  <= '0;
            in_rows_q  <= '0;
            out_rows_q <= '0;
            rows_sent  <= '0;
            outs_rcvd  <= '0;
            idle_cnt   <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                w_width_q  <= cmd_w_width;
                w_height_q <= cmd_w_height;
                op_sel_q   <= cmd_op_sel;
                ifmap_w_q  <= cmd_ifmap_w;
                in_rows_q  <= cmd_in_rows;
                out_rows_q <= cmd_out_rows;
                rows_sent  <= '0;
                outs_rcvd  <= '0;
                idle_cnt   <= '0;
                err_q      <= 1'b0;
            end else begin
                if (sa_data_iv) rows_sent <= rows_inc;
                outs_rcvd <= outs_nx;
                if (state != S_DRAIN || sa_data_ov) begin
                    idle_cnt <= '0;
                end else if (idle_cnt != '1) begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
                if (err_set) err_q <= 1'b1;
            end
        end
    end

    assign sa_w_width   = w_width_q;
    assign sa_w_height  = w_height_q;
    assign sa_op_sel    = op_sel_q;
    assign sa_ifmap_i_w = ifmap_w_q;
    assign res_valid    = beat;
    assign res_data     = beat ? sa_data_od : '0;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl. Cycle numbers in each task are counted
// from the command-accept cycle (c=0); inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge.
module tb_sa_seq_ctrl;

    localparam int WIDTH      = 8;
    localparam int HEIGHT     = 8;
    localparam int DATA_WIDTH = 8;
    localparam int PSUM_WIDTH = DATA_WIDTH*2+$clog2(HEIGHT);
    localparam int CNT_W      = 8;
    localparam int DRAIN_TO   = 64;
    localparam int WTW        = HEIGHT*WIDTH*DATA_WIDTH;
    localparam int SRW        = WIDTH*DATA_WIDTH;
    localparam int RSW        = WIDTH*PSUM_WIDTH;

    logic             clk = 1'b0;
    logic             nrst;
    logic             cmd_valid, cmd_ready;
    logic [3:0]       cmd_w_width, cmd_w_height, cmd_ifmap_w;
    logic             cmd_op_sel;
    logic [CNT_W-1:0] cmd_in_rows, cmd_out_rows;
    logic             wt_valid, wt_ready;
    logic [WTW-1:0]   wt_data;
    logic             src_valid, src_ready;
    logic [SRW-1:0]   src_data;
    logic             abort;
    logic             sa_load_layer_info, sa_op_sel, sa_weight_iv, sa_data_iv;
    logic [3:0]       sa_w_width, sa_w_height, sa_ifmap_i_w;
    logic [WTW-1:0]   sa_weight_id;
    logic [SRW-1:0]   sa_data_id;
    logic             sa_data_ov;
    logic [RSW-1:0]   sa_data_od;
    logic             res_valid;
    logic [RSW-1:0]   res_data;
    logic             busy, done, err;

    int vecs = 0;
    int errs = 0;

    logic [6:0]     ctl, exp;
    logic [12:0]    cfg_exp;
    logic [SRW-1:0] ed;
    logic [RSW-1:0] er;
    logic [WTW-1:0] wt_pat;

    assign ctl = {cmd_ready, sa_load_layer_info, sa_weight_iv, sa_data_iv, res_valid, done, busy};

    always #5 clk = ~clk;

    sa_seq_ctrl #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_WIDTH(DATA_WIDTH),
        .PSUM_WIDTH(PSUM_WIDTH), .CNT_W(CNT_W), .DRAIN_TIMEOUT(DRAIN_TO)
    ) dut (
        .clk(clk), .nrst(nrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_w_width(cmd_w_width), .cmd_w_height(cmd_w_height),
        .cmd_op_sel(cmd_op_sel), .cmd_ifmap_w(cmd_ifmap_w),
        .cmd_in_rows(cmd_in_rows), .cmd_out_rows(cmd_out_rows),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_data(wt_data),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .abort(abort),
        .sa_load_layer_info(sa_load_layer_info),
        .sa_w_width(sa_w_width), .sa_w_height(sa_w_height),
        .sa_op_sel(sa_op_sel), .sa_ifmap_i_w(sa_ifmap_i_w),
        .sa_weight_iv(sa_weight_iv), .sa_weight_id(sa_weight_id),
        .sa_data_iv(sa_data_iv), .sa_data_id(sa_data_id),
        .sa_data_ov(sa_data_ov), .sa_data_od(sa_data_od),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done), .err(err)
    );

    task automatic idle_inputs;
        cmd_valid  = 1'b0;
        wt_valid   = 1'b0;
        src_valid  = 1'b0;
        abort      = 1'b0;
        sa_data_ov = 1'b0;
        sa_data_od = '0;
        src_data   = '0;
    endtask

    task automatic set_cmd(input logic [3:0] w, input logic [3:0] h, input logic op,
                           input logic [3:0] iw, input int inr, input int outr);
        cmd_w_width  = w;
        cmd_w_height = h;
        cmd_op_sel   = op;
        cmd_ifmap_w  = iw;
        cmd_in_rows  = CNT_W'(inr);
        cmd_out_rows = CNT_W'(outr);
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        vecs++;
        if (ctl !== 7'b1000000) begin
            $display("FAIL reset_ctl got %b exp %b", ctl, 7'b1000000); errs++;
        end
        vecs++;
        if ({err, wt_ready, src_ready, sa_w_width, sa_weight_id, res_data} !== '0) begin
            $display("FAIL reset_outs err=%b wt_ready=%b src_ready=%b w_width=%h", err, wt_ready, src_ready, sa_w_width);
            errs++;
        end
        next_cycle();
        nrst = 1'b1;
    endtask

    task automatic test_conv;
        set_cmd(4'd3, 4'd3, 1'b0, 4'd8, 10, 8);
        for (int c = 0; c <= 20; c++) begin
            cmd_valid  = (c == 0);
            wt_valid   = 1'b1;
            src_valid  = 1'b1;
            src_data   = {WIDTH{DATA_WIDTH'(c)}};
            sa_data_ov = (c >= 10 && c <= 17);
            sa_data_od = {WIDTH{PSUM_WIDTH'(c*7+1)}};
            @(negedge clk);
            exp = {c == 0 || c >= 19, c == 1, c == 3, c >= 5 && c <= 14,
                   c >= 10 && c <= 17, c == 18, c >= 1 && c <= 18};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL conv_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            if (c == 2) begin
                vecs++;
                if ({sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w} !== {4'd3, 4'd3, 1'b0, 4'd8}) begin
                    $display("FAIL conv_cfg got %h/%h/%b/%h exp 3/3/0/8", sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w);
                    errs++;
                end
            end
            if (c == 3) begin
                vecs++;
                if (sa_weight_id !== wt_pat) begin
                    $display("FAIL conv_weight_id got %h exp %h", sa_weight_id, wt_pat); errs++;
                end
            end
            if (c == 4 || c == 9) begin
                ed = (c == 9) ? {WIDTH{8'd9}} : '0;
                vecs++;
                if (sa_data_id !== ed) begin
                    $display("FAIL conv_data_id c=%0d got %h exp %h", c, sa_data_id, ed); errs++;
                end
            end
            if (c == 13) begin
                er = {WIDTH{19'd92}};
                vecs++;
                if (res_data !== er) begin
                    $display("FAIL conv_res_data got %h exp %h", res_data, er); errs++;
                end
            end
            if (c == 19) begin
                vecs++;
                if (err !== 1'b0) begin
                    $display("FAIL conv_err got %b exp 0", err); errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_mul;
        set_cmd(4'd8, 4'd8, 1'b1, 4'd1, 8, 8);
        for (int c = 0; c <= 30; c++) begin
            cmd_valid  = (c == 0);
            wt_valid   = 1'b1;
            src_valid  = (c % 2 == 1);
            sa_data_ov = (c >= 20 && c <= 27);
            @(negedge clk);
            exp = {c == 0 || c >= 29, c == 1, c == 3, c >= 5 && c <= 19 && c % 2 == 1,
                   c >= 20 && c <= 27, c == 28, c >= 1 && c <= 28};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL mul_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            vecs++;
            if (src_ready !== (c >= 5 && c <= 19)) begin
                $display("FAIL mul_src_ready c=%0d got %b", c, src_ready); errs++;
            end
            if (c == 10) begin
                vecs++;
                if ({sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w} !== {4'd8, 4'd8, 1'b1, 4'd1}) begin
                    $display("FAIL mul_cfg got %h/%h/%b/%h exp 8/8/1/1", sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w);
                    errs++;
                end
            end
            if (c == 29) begin
                vecs++;
                if (err !== 1'b0) begin
                    $display("FAIL mul_err got %b exp 0", err); errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_timeout;
        set_cmd(4'd3, 4'd3, 1'b0, 4'd8, 2, 8);
        for (int c = 0; c <= 78; c++) begin
            cmd_valid  = (c == 0);
            wt_valid   = 1'b1;
            src_valid  = 1'b1;
            sa_data_ov = (c >= 7 && c <= 11);
            @(negedge clk);
            exp = {c == 0 || c >= 76, c == 1, c == 3, c == 5 || c == 6,
                   c >= 7 && c <= 11, c == 75, c >= 1 && c <= 75};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL timeout_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            if (c == 74 || c == 75 || c == 77) begin
                vecs++;
                if (err !== (c != 74)) begin
                    $display("FAIL timeout_err c=%0d got %b exp %b", c, err, c != 74); errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_wt_delay;
        set_cmd(4'd5, 4'd2, 1'b1, 4'd7, 0, 0);
        cfg_exp = {4'd5, 4'd2, 1'b1, 4'd7};
        for (int c = 0; c <= 28; c++) begin
            cmd_valid  = (c == 0);
            wt_valid   = (c >= 23);
            sa_data_ov = (c == 10);
            @(negedge clk);
            exp = {c == 0 || c >= 27, c == 1, c == 23, 1'b0, 1'b0, c == 26, c >= 1 && c <= 26};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL wtdelay_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            vecs++;
            if (wt_ready !== (c >= 3 && c <= 23)) begin
                $display("FAIL wtdelay_wt_ready c=%0d got %b", c, wt_ready); errs++;
            end
            if (c >= 1) begin
                vecs++;
                if ({sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w} !== cfg_exp) begin
                    $display("FAIL wtdelay_cfg c=%0d got %h exp %h", c,
                             {sa_w_width, sa_w_height, sa_op_sel, sa_ifmap_i_w}, cfg_exp);
                    errs++;
                end
            end
            if (c == 10 || c == 23) begin
                vecs++;
                if (sa_weight_id !== ((c == 23) ? wt_pat : '0)) begin
                    $display("FAIL wtdelay_weight_id c=%0d got %h", c, sa_weight_id); errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_abort;
        for (int c = 0; c <= 18; c++) begin
            if (c == 0) set_cmd(4'd3, 4'd3, 1'b0, 4'd8, 10, 8);
            if (c == 10) set_cmd(4'd6, 4'd4, 1'b1, 4'd2, 0, 0);
            cmd_valid = (c == 0 || c == 10);
            wt_valid  = 1'b1;
            src_valid = 1'b1;
            abort     = (c == 8);
            @(negedge clk);
            exp = {c == 0 || c == 10 || c >= 17, c == 1 || c == 11, c == 3 || c == 13,
                   c >= 5 && c <= 7, 1'b0, c == 9 || c == 16,
                   (c >= 1 && c <= 9) || (c >= 11 && c <= 16)};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL abort_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            if (c >= 8 && c <= 11) begin
                vecs++;
                if (err !== (c != 8 && c != 11)) begin
                    $display("FAIL abort_err c=%0d got %b exp %b", c, err, c != 8 && c != 11); errs++;
                end
            end
            if (c == 12) begin
                vecs++;
                if (sa_w_width !== 4'd6) begin
                    $display("FAIL abort_new_cfg got %h exp 6", sa_w_width); errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_drain;
        set_cmd(4'd3, 4'd3, 1'b0, 4'd8, 1, 4);
        for (int c = 0; c <= 20; c++) begin
            cmd_valid = (c == 0);
            wt_valid  = 1'b1;
            src_valid = 1'b1;
            if (c == 10) nrst = 1'b0;
            if (c == 12) nrst = 1'b1;
            @(negedge clk);
            exp = {c == 0 || c >= 10, c == 1, c == 3, c == 5, 1'b0, 1'b0, c >= 1 && c <= 9};
            vecs++;
            if (ctl !== exp) begin
                $display("FAIL rstdrain_ctl c=%0d got %b exp %b", c, ctl, exp); errs++;
            end
            if (c == 10 || c == 13) begin
                vecs++;
                if ({err, wt_ready, src_ready, sa_w_width, sa_op_sel} !== '0) begin
                    $display("FAIL rstdrain_outs c=%0d err=%b wt_ready=%b src_ready=%b w_width=%h",
                             c, err, wt_ready, src_ready, sa_w_width);
                    errs++;
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        nrst   = 1'b0;
        wt_pat = {HEIGHT*WIDTH{8'hA5}};
        wt_data = wt_pat;
        set_cmd(4'd0, 4'd0, 1'b0, 4'd0, 0, 0);
        idle_inputs();
        test_reset();
        test_conv();
        test_mul();
        test_timeout();
        test_wt_delay();
        test_abort();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/sa_seq_ctrl.md
Name: sa_seq_ctrl

Overview:
Layer sequencer for the scalable systolic array (scalable_SA).
- Accepts one layer command per handshake.
- Issues the layer-info load, the weight load and the row-by-row ifmap stream.
- Counts array outputs until the layer completes, then reports done/error.
- Sits between the layer-command/buffer logic and a single scalable_SA instance, owning all of its control inputs.

Parameters:
WIDTH, 8, array columns
HEIGHT, 8, array rows
DATA_WIDTH, 8, operand width
PSUM_WIDTH, DATA_WIDTH*2+$clog2(HEIGHT), output word width
CNT_W, 8, width of row/output counters
DRAIN_TIMEOUT, 64, cycles without sa_data_ov in DRAIN before error

Ports:
clk  in  1  clock
nrst  in  1  async active-low reset
cmd_valid  in  1  layer command valid
cmd_ready  out  1  controller idle, accepts command
cmd_w_width  in  4  kernel/matrix width
cmd_w_height  in  4  kernel/matrix height
cmd_op_sel  in  1  0=CONV, 1=MUL
cmd_ifmap_w  in  4  ifmap width / inner dimension n
cmd_in_rows  in  CNT_W  ifmap rows to stream
cmd_out_rows  in  CNT_W  expected sa_data_ov beats
wt_valid  in  1  weight block available
wt_ready  out  1  weight block consumed this cycle
wt_data  in  HEIGHT*WIDTH*DATA_WIDTH  weight block
src_valid  in  1  ifmap row available
src_ready  out  1  ifmap row consumed
src_data  in  WIDTH*DATA_WIDTH  ifmap row
abort  in  1  sync abort of current layer
sa_load_layer_info  out  1  to array
sa_w_width  out  4  to array
sa_w_height  out  4  to array
sa_op_sel  out  1  to array
sa_ifmap_i_w  out  4  to array
sa_weight_iv  out  1  to array
sa_weight_id  out  HEIGHT*WIDTH*DATA_WIDTH  to array
sa_data_iv  out  1  to array
sa_data_id  out  WIDTH*DATA_WIDTH  to array
sa_data_ov  in  1  array output valid
sa_data_od  in  WIDTH*PSUM_WIDTH  array output
res_valid  out  1  result beat valid
res_data  out  WIDTH*PSUM_WIDTH  result beat
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag; cleared on next command accept

Behaviour:
- Reset values:
  - All control outputs and data buses 0; err=0.
  - cmd_ready=1 only in IDLE.
- States: IDLE, CFG, GAP1, WLOAD, GAP2, STREAM, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch all cmd fields, clear counters and err, go to CFG.
- CFG: sa_load_layer_info=1 for exactly one cycle → GAP1.
- Config outputs: sa_w_width/height/op_sel/ifmap_i_w driven from latched registers, held stable from CFG until the next command is accepted.
- GAP1: one idle cycle → WLOAD.
- WLOAD:
  - wt_ready=1. On wt_valid: sa_weight_iv=1 and sa_weight_id=wt_data combinationally in that cycle → GAP2.
  - Waits indefinitely for wt_valid.
- GAP2: one idle cycle → STREAM, or → DRAIN if in_rows==0.
- STREAM:
  - src_ready=1 while rows_sent<in_rows.
  - sa_data_iv=src_valid&src_ready, sa_data_id=src_data (combinational).
  - rows_sent increments per transfer; last transfer → DRAIN.
  - src_valid gaps become sa_data_iv=0 bubbles; no stall otherwise.
- Result forwarding (STREAM and DRAIN):
  - res_valid=sa_data_ov, res_data=sa_data_od (combinational); outs_rcvd increments per beat.
  - In other states res_valid=0 and beats are dropped.
- DRAIN:
  - outs_rcvd reaching out_rows → DONE.
  - Idle counter resets on each sa_data_ov; reaching DRAIN_TIMEOUT sets err → DONE.
  - out_rows==0 → DONE on first DRAIN cycle.
- Excess output: beat after outs_rcvd==out_rows in STREAM sets err (beat still forwarded).
- DONE: done=1 for one cycle → IDLE.
- abort:
  - In any non-IDLE state: next state DONE, err=1, no further sa_* pulses.
  - abort in IDLE is ignored.
- Counters saturate at 2^CNT_W-1; no wrap.
- Async reset mid-layer: immediately to IDLE with reset values; no done pulse.

Test Plan:
- CONV layer (w 3x3, op_sel=0, ifmap_w=8, in_rows=10, out_rows=8), wt_valid and src_valid always high, array model returns 8 beats → load_layer_info at cycle 1 after accept, weight_iv at cycle 3, data_iv high cycles 5–14, done once after 8th res_valid, err=0.
- MUL layer (8x8, op_sel=1, ifmap_w=1, in_rows=8, out_rows=8), src_valid toggling 1/0 → 8 transfers over 16 cycles, sa_data_iv mirrors transfers, done after 8 beats.
- Array returns only 5 of out_rows=8 → err=1 and done exactly DRAIN_TIMEOUT=64 cycles after last beat.
- wt_valid delayed 20 cycles → controller holds in WLOAD, sa_weight_iv single pulse at arrival, config outputs stable throughout.
- abort asserted mid-STREAM after 3 rows → no further sa_data_iv, done next cycle, err=1; new command accepted next IDLE cycle with err cleared.
- nrst pulsed low during DRAIN → all outputs 0, cmd_ready=1 after release, no done pulse.
